uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmit byte path between NUM_REQ message sources and
//   one error source. Each grant latches one MSG_BYTES-byte message, which is then

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte path between NUM_REQ message sources
// and a priority error source; an error message halts the block until reset.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MSG_BYTES = 3,
    localparam int MSG_W    = 8 * MSG_BYTES
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       req_ack,
    input  logic                     err_valid,
    input  logic [MSG_W-1:0]         err_msg,
    output logic                     err_ack,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     halted,
    output logic [15:0]              msg_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   byte_idx_r;
    logic [MSG_W-1:0]   msg_r;
    logic               err_flag_r;

    logic               found_s;
    logic               hit_s;
    logic [PTR_W-1:0]   gnt_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic [MSG_W-1:0]   grant_msg_s;
    logic               grant_en_s;
    logic [IDX_W-1:0]   next_idx_s;
    int                 cand_s;

    // Byte idx of a message, counted from the most significant byte.
    function automatic logic [7:0] byte_of(input logic [MSG_W-1:0] msg,
                                           input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (idx == i[IDX_W-1:0]) begin
                b = msg[MSG_W-1-8*i -: 8];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Round-robin search from rr_ptr_r; acks are combinational so the requester sees them at the grant edge.
    always_comb begin
        found_s     = 1'b0;
        hit_s       = 1'b0;
        gnt_s       = '0;
        grant_msg_s = '0;
        cand_s      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s      = int'(rr_ptr_r) + k;
            cand_s      = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
            hit_s       = !found_s && req_valid[cand_s[PTR_W-1:0]];
            gnt_s       = hit_s ? cand_s[PTR_W-1:0] : gnt_s;
            grant_msg_s = hit_s ? req_msg[cand_s*MSG_W +: MSG_W] : grant_msg_s;
            found_s     = found_s | hit_s;
        end
        next_ptr_s = (int'(gnt_s) + 1 >= NUM_REQ) ? '0 : PTR_W'(int'(gnt_s) + 1);
        next_idx_s = byte_idx_r + 1'b1;
        grant_en_s = n_reset && (state_r == ST_IDLE);
        err_ack    = grant_en_s && err_valid;
        if (grant_en_s && !err_valid && found_s) begin
            req_ack = NUM_REQ'(1) << gnt_s;
        end else begin
            req_ack = '0;
        end
    end

    // Main FSM: latch a granted message, stream it MSB byte first, halt after an error message.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            byte_idx_r <= '0;
            msg_r      <= '0;
            err_flag_r <= 1'b0;
            tx_byte    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            msg_count  <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (err_valid) begin
                        msg_r      <= err_msg;
                        err_flag_r <= 1'b1;
                        byte_idx_r <= '0;
                        tx_byte    <= err_msg[MSG_W-1 -: 8];
                        tx_valid   <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_SEND;
                    end else if (found_s) begin
                        msg_r      <= grant_msg_s;
                        rr_ptr_r   <= next_ptr_s;
                        byte_idx_r <= '0;
                        tx_byte    <= grant_msg_s[MSG_W-1 -: 8];
                        tx_valid   <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_SEND;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (byte_idx_r == LAST_IDX) begin
                            byte_idx_r <= '0;
                            msg_count  <= msg_count + 16'd1;
                            tx_valid   <= 1'b0;
                            tx_byte    <= 8'h00;
                            if (err_flag_r) begin
                                halted  <= 1'b1;
                                state_r <= ST_HALT;
                            end else begin
                                busy    <= 1'b0;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            byte_idx_r <= next_idx_s;
                            tx_byte    <= byte_of(msg_r, next_idx_s);
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter, checked every cycle against a
// queue-based reference model of grants, byte stream and counters.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int MSG_BYTES = 3;
    localparam int MSG_W     = 8 * MSG_BYTES;

    logic                     clk = 1'b0;
    logic                     n_reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*MSG_W-1:0] req_msg;
    logic [NUM_REQ-1:0]       req_ack;
    logic                     err_valid;
    logic [MSG_W-1:0]         err_msg;
    logic                     err_ack;
    logic [7:0]               tx_byte;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     busy;
    logic                     halted;
    logic [15:0]              msg_count;

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    bit          m_sending;
    bit          m_halted;
    bit          m_err;
    int          m_ptr;
    logic [15:0] m_count;
    logic [7:0]  m_q[$];

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MSG_BYTES(MSG_BYTES)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid(req_valid), .req_msg(req_msg), .req_ack(req_ack),
        .err_valid(err_valid), .err_msg(err_msg), .err_ack(err_ack),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .halted(halted), .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_msg(input logic [MSG_W-1:0] msg);
        for (int b = MSG_BYTES - 1; b >= 0; b--) m_q.push_back(msg[8*b +: 8]);
    endtask

    // One clock: compare mid-cycle, advance the model for the coming edge, return after it.
    task automatic step();
        logic [NUM_REQ-1:0] exp_req;
        logic               exp_err;
        int                 g;
        @(negedge clk);
        exp_req = '0;
        exp_err = 1'b0;
        g = -1;
        if (n_reset && !m_sending && !m_halted) begin
            if (err_valid) begin
                exp_err = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                end
                if (g >= 0) exp_req[g] = 1'b1;
            end
        end
        check_eq("req_ack", 32'(req_ack), 32'(exp_req));
        check_eq("err_ack", 32'(err_ack), 32'(exp_err));
        check_eq("tx_valid", 32'(tx_valid), 32'(m_sending));
        if (m_sending) check_eq("tx_byte", 32'(tx_byte), 32'(m_q[0]));
        check_eq("busy", 32'(busy), 32'(m_sending || m_halted));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("msg_count", 32'(msg_count), 32'(m_count));

        if (!n_reset) begin
            m_sending = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_ptr = 0; m_count = 16'h0000;
            m_q.delete();
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_sending) begin
            if (tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_count   = m_count + 16'd1;
                    m_sending = 1'b0;
                    if (m_err) m_halted = 1'b1;
                end
            end
        end else if (exp_err) begin
            push_msg(err_msg);
            m_err = 1'b1;
            m_sending = 1'b1;
        end else if (g >= 0) begin
            push_msg(req_msg[g*MSG_W +: MSG_W]);
            m_ptr = (g + 1) % NUM_REQ;
            m_sending = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_reset = 1'b0; req_valid = '0; req_msg = '0; err_valid = 1'b0; err_msg = '0; tx_ready = 1'b1;
        m_sending = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_ptr = 0; m_count = 16'h0000;

        // Reset held with every requester asking; first grant goes to req 0 after release
        req_valid = 3'b111;
        run(2);
        n_reset = 1'b1;
        step();
        req_valid = '0;
        run(5);

        // Single message from requester 1
        req_valid = 3'b010;
        req_msg[1*MSG_W +: MSG_W] = 24'hA1B2C3;
        step();
        req_valid = '0;
        run(5);

        // Round robin with all requesters continuously asking
        n_reset = 1'b0; run(1); n_reset = 1'b1;
        req_valid = 3'b111;
        run(24);
        req_valid = '0;
        run(5);

        // Backpressure on the middle byte
        req_valid = 3'b001;
        req_msg[0 +: MSG_W] = 24'h112233;
        step();
        req_valid = '0;
        step();
        tx_ready = 1'b0;
        run(5);
        tx_ready = 1'b1;
        run(5);

        // Error wins over a same-cycle request, then the block halts
        err_valid = 1'b1; err_msg = 24'hEE0001; req_valid = 3'b001;
        step();
        err_valid = 1'b0;
        run(3);
        req_valid = 3'b111;
        run(20);
        n_reset = 1'b0;
        step();
        n_reset = 1'b1; req_valid = '0;
        run(2);

        // Reset after the first byte of a message
        req_valid = 3'b010;
        step();
        req_valid = '0;
        step();
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        req_valid = 3'b100;
        req_msg[2*MSG_W +: MSG_W] = 24'h5A6B7C;
        step();
        req_valid = '0;
        run(5);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            req_valid = NUM_REQ'($urandom());
            for (int i = 0; i < NUM_REQ; i++) req_msg[i*MSG_W +: MSG_W] = MSG_W'($urandom());
            err_valid = ($urandom_range(0, 149) == 0);
            err_msg   = MSG_W'($urandom());
            tx_ready  = ($urandom_range(0, 9) < 7);
            n_reset   = m_halted ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 299) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
